// File: rtl/switch_event_fifo.sv
// switch_event_fifo: detects edges on the debounced switch vector and queues
// them as (index, level) events in a first-word-fall-through FIFO. When more
// than one lane is waiting, the lowest index is queued first.
//
// Handshake: event_valid is high whenever the FIFO head holds an event. The
// head (event_index/event_level) is held stable until it is accepted. A pop
// happens on a rising clock edge where event_valid && event_ready. If
// event_ready is high while event_valid is low, nothing happens.
module switch_event_fifo #(
  parameter int input_count = 16,
  parameter int fifo_depth  = 8,
  localparam int idx_w = (input_count > 1) ? $clog2(input_count) : 1,
  localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1,
  localparam int cnt_w = $clog2(fifo_depth) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [input_count-1:0] switch_inputs,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [idx_w-1:0]       event_index,
  output logic                   event_level,
  output logic [cnt_w-1:0]       event_count,
  output logic                   overflow,
  input  logic                   overflow_clear
);

  logic [input_count-1:0] prev;
  logic [input_count-1:0] pending;
  logic                   primed;
  logic [input_count-1:0] change;
  logic [input_count-1:0] grant;
  logic [idx_w-1:0]       grant_idx;
  logic                   grant_found;
  logic                   push;
  logic                   pop;
  logic                   push_allowed;

  // Each entry is {lane index, new level}.
  logic [idx_w:0]         mem [fifo_depth];
  logic [ptr_w-1:0]       rd_ptr;
  logic [ptr_w-1:0]       wr_ptr;
  logic [cnt_w-1:0]       count;
  logic [idx_w:0]         head;

  // Edge detection. The first clock after reset only primes prev, so any
  // switch that is already on at reset does not produce an event.
  always_comb begin
    change = primed ? (switch_inputs ^ prev) : '0;
  end

  // Pick the lowest pending lane. A lane is granted only if it can be pushed
  // this cycle, which is either because there is free space or because a pop
  // is happening on the same edge.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < input_count; i++) begin
      if (pending[i] && !grant_found) begin
        grant_found = 1'b1;
        grant_idx   = idx_w'(i);
      end
    end
    pop          = event_valid && event_ready;
    push_allowed = (count < cnt_w'(fifo_depth)) || pop;
    push         = grant_found && push_allowed;
    grant        = '0;
    if (push) grant[grant_idx] = 1'b1;
  end

  // prev, primed and the pending mask. While the FIFO is full, pending bits
  // stay set until there is space for them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev    <= '0;
      pending <= '0;
      primed  <= 1'b0;
    end else begin
      prev    <= switch_inputs;
      primed  <= 1'b1;
      pending <= (pending & ~grant) | change;
    end
  end

  // Sticky overflow flag. It is set when a new edge arrives on a lane that
  // already has an event waiting, so the two edges are merged into one.
  // Setting takes priority over clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (|(change & pending & ~grant)) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

  // FIFO storage. The level written is the lane's level at the time of the
  // push, so a lane that toggles twice before it is served gives one event
  // carrying the latest level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {grant_idx, prev[grant_idx]};
  end

  // FIFO pointers and occupancy. The pointers wrap naturally. Because the
  // occupancy is a separate counter, full and empty can still be told apart
  // when the two pointers are equal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head outputs. These are forced to zero when the FIFO is empty, so the
  // storage never needs to be reset.
  always_comb begin
    head        = mem[rd_ptr];
    event_valid = (count != '0);
    event_count = count;
    event_index = event_valid ? head[idx_w:1] : '0;
    event_level = event_valid ? head[0] : 1'b0;
  end

endmodule

// File: tb/tb_switch_event_fifo.sv
// Directed bench for switch_event_fifo (input_count=16, fifo_depth=8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_switch_event_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] switch_inputs = '0;
  logic        event_valid;
  logic        event_ready = 1'b0;
  logic [3:0]  event_index;
  logic        event_level;
  logic [3:0]  event_count;
  logic        overflow;
  logic        overflow_clear = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  switch_event_fifo #(.input_count(16), .fifo_depth(8)) dut (
    .clk(clk),
    .reset(reset),
    .switch_inputs(switch_inputs),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .event_index(event_index),
    .event_level(event_level),
    .event_count(event_count),
    .overflow(overflow),
    .overflow_clear(overflow_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input logic [15:0] sw);
    switch_inputs  = sw;
    event_ready    = 1'b0;
    overflow_clear = 1'b0;
    reset          = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    switch_inputs = 16'h0005;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({event_valid, event_count, event_index, event_level, overflow} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {event_valid, event_count, event_index, event_level, overflow});
    end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if (event_valid !== 1'b0 || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got valid=%b ovf=%b expected 0 0", k, event_valid, overflow);
      end
    end
  endtask

  task automatic test_single_edge();
    do_reset(16'h0000);
    switch_inputs = 16'h0008;
    @(negedge clk);
    vectors++;
    if (event_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_1clk: got valid=%b expected 0", event_valid);
    end
    @(negedge clk);
    vectors++;
    if (event_valid !== 1'b1 || event_index !== 4'd3 || event_level !== 1'b1) begin
      miscompares++;
      $display("FAIL rise_lane3: got v=%b i=%0d l=%b expected v=1 i=3 l=1", event_valid, event_index, event_level);
    end
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    vectors++;
    if (event_valid !== 1'b0 || event_count !== 4'd0) begin
      miscompares++;
      $display("FAIL rise_drain: got v=%b cnt=%0d expected v=0 cnt=0", event_valid, event_count);
    end
    switch_inputs = 16'h0000;
    repeat (2) @(negedge clk);
    vectors++;
    if (event_valid !== 1'b1 || event_index !== 4'd3 || event_level !== 1'b0) begin
      miscompares++;
      $display("FAIL fall_lane3: got v=%b i=%0d l=%b expected v=1 i=3 l=0", event_valid, event_index, event_level);
    end
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    vectors++;
    if (event_count !== 4'd0) begin
      miscompares++;
      $display("FAIL fall_drain: got cnt=%0d expected 0", event_count);
    end
  endtask

  task automatic test_multi_edge();
    logic [3:0] exp_idx [4];
    exp_idx[0] = 4'd0; exp_idx[1] = 4'd5; exp_idx[2] = 4'd10; exp_idx[3] = 4'd15;
    do_reset(16'h0000);
    switch_inputs = 16'h8421;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (event_count !== 4'(k)) begin
        miscompares++;
        $display("FAIL multi_fill step %0d: got cnt=%0d expected %0d", k, event_count, k);
      end
    end
    event_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (event_valid !== 1'b1 || event_index !== exp_idx[k] || event_level !== 1'b1) begin
        miscompares++;
        $display("FAIL multi_order pop %0d: got v=%b i=%0d l=%b expected v=1 i=%0d l=1",
                 k, event_valid, event_index, event_level, exp_idx[k]);
      end
      @(negedge clk);
    end
    event_ready = 1'b0;
    vectors++;
    if (event_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL multi_empty: got v=%b expected 0", event_valid);
    end
  endtask

  task automatic test_full();
    do_reset(16'h0000);
    switch_inputs = 16'h03FF;
    repeat (12) @(negedge clk);
    vectors++;
    if (event_count !== 4'd8 || event_index !== 4'd0) begin
      miscompares++;
      $display("FAIL full_count: got cnt=%0d i=%0d expected cnt=8 i=0", event_count, event_index);
    end
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    vectors++;
    if (event_count !== 4'd8 || event_index !== 4'd1) begin
      miscompares++;
      $display("FAIL full_push_pop: got cnt=%0d i=%0d expected cnt=8 i=1", event_count, event_index);
    end
    event_ready = 1'b1;
    for (int k = 1; k < 10; k++) begin
      vectors++;
      if (event_valid !== 1'b1 || event_index !== 4'(k) || event_level !== 1'b1) begin
        miscompares++;
        $display("FAIL full_order pop %0d: got v=%b i=%0d l=%b expected v=1 i=%0d l=1",
                 k, event_valid, event_index, event_level, k);
      end
      @(negedge clk);
    end
    event_ready = 1'b0;
    vectors++;
    if (event_count !== 4'd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_end: got cnt=%0d ovf=%b expected 0 0", event_count, overflow);
    end
  endtask

  task automatic test_overflow();
    do_reset(16'h0000);
    switch_inputs = 16'hFF00;
    repeat (12) @(negedge clk);
    vectors++;
    if (event_count !== 4'd8 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_prefill: got cnt=%0d ovf=%b expected 8 0", event_count, overflow);
    end
    switch_inputs = 16'hFF04;
    @(negedge clk);
    switch_inputs = 16'hFF00;
    @(negedge clk);
    vectors++;
    if (overflow !== 1'b1 || event_count !== 4'd8) begin
      miscompares++;
      $display("FAIL ovf_set: got ovf=%b cnt=%0d expected 1 8", overflow, event_count);
    end
    event_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (event_valid !== 1'b1 || event_index !== ((k < 8) ? 4'(8 + k) : 4'd2) ||
          event_level !== ((k < 8) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL ovf_order pop %0d: got v=%b i=%0d l=%b expected v=1 i=%0d l=%b",
                 k, event_valid, event_index, event_level,
                 (k < 8) ? 8 + k : 2, (k < 8) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    event_ready = 1'b0;
    vectors++;
    if (event_valid !== 1'b0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_once: got v=%b ovf=%b expected v=0 ovf=1", event_valid, overflow);
    end
    overflow_clear = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(16'h0000);
    switch_inputs = 16'h001F;
    repeat (8) @(negedge clk);
    vectors++;
    if (event_count !== 4'd5) begin
      miscompares++;
      $display("FAIL mid_count: got %0d expected 5", event_count);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({event_valid, event_count, event_index, event_level, overflow} !== 11'd0) begin
      miscompares++;
      $display("FAIL mid_async: got %0h expected 0",
               {event_valid, event_count, event_index, event_level, overflow});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (event_valid !== 1'b0 || event_count !== 4'd0) begin
      miscompares++;
      $display("FAIL mid_stale: got v=%b cnt=%0d expected 0 0", event_valid, event_count);
    end
    switch_inputs = 16'h001E;
    repeat (2) @(negedge clk);
    vectors++;
    if (event_valid !== 1'b1 || event_index !== 4'd0 || event_level !== 1'b0 || event_count !== 4'd1) begin
      miscompares++;
      $display("FAIL mid_after: got v=%b i=%0d l=%b cnt=%0d expected 1 0 0 1",
               event_valid, event_index, event_level, event_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_multi_edge();
    test_full();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
